// File: rtl/iob_pack_if.sv
// iob_pack_if: FIFO-side handshake bundle for the packer.
// master (packer): drives read_o, write_o, wdata_o; samples rready_i, rdata_i, wready_i.
// slave (FIFO side): the mirror image.
interface iob_pack_if #(
  parameter int DATA_W = 21
);
  logic              read_o;
  logic              rready_i;
  logic [DATA_W-1:0] rdata_i;
  logic              write_o;
  logic              wready_i;
  logic [DATA_W-1:0] wdata_o;
  modport master (output read_o, write_o, wdata_o, input rready_i, rdata_i, wready_i);
  modport slave (input read_o, write_o, wdata_o, output rready_i, rdata_i, wready_i);
endinterface

// File: rtl/iob_pack.sv
// iob_pack: packs variable-width items MSB-first into DATA_W-bit words.
// Ports: clk_i clock; cke_i clock enable; rst_i sync active-high reset;
//        wrap_i no-straddle mode; width_i item width (1..DATA_W); flush_i drain partial word;
//        bus: read_o/rready_i/rdata_i upstream FIFO (1-cycle read latency),
//             write_o/wready_i/wdata_o downstream FIFO.
module iob_pack #(
  parameter int DATA_W = 21
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      rst_i,
  input  logic                      wrap_i,
  input  logic [$clog2(DATA_W):0]   width_i,
  input  logic                      flush_i,
  iob_pack_if.master                bus
);
  localparam int LW = $clog2(2 * DATA_W) + 1;
  localparam logic [LW-1:0] DW = LW'(DATA_W);
  logic [2*DATA_W-1:0] buf_q, buf_s, item;
  logic [LW-1:0] level, lvl_s, w, occ;
  logic [DATA_W-1:0] mask;
  logic pend, legal, run, full_wr, wrap_wr, flush_wr;
  assign w = LW'(width_i);
  assign legal = w != '0 && w <= DW;
  assign run = cke_i && !rst_i;
  // occupancy counts the item already requested but not yet landed
  assign occ = level + (pend ? w : '0);
  assign full_wr = !wrap_i && level >= DW;
  assign wrap_wr = wrap_i && !pend && level + w > DW;
  assign flush_wr = flush_i && !pend && level != '0 && level < DW;
  assign bus.write_o = run && bus.wready_i && (full_wr || wrap_wr || flush_wr);
  assign bus.read_o = run && bus.rready_i && !flush_i && legal &&
                      (wrap_i ? occ + w <= DW : occ <= DW);
  // a full continuous word shifts out; a wrap or flush word empties the accumulator
  assign buf_s = !bus.write_o ? buf_q : full_wr ? buf_q << DATA_W : '0;
  assign lvl_s = !bus.write_o ? level : full_wr ? level - DW : '0;
  // left-align the item in the accumulator, then drop it just below the valid bits
  assign mask = ~({DATA_W{1'b1}} << width_i);
  assign item = ({bus.rdata_i & mask, {DATA_W{1'b0}}} << (DW - w)) >> lvl_s;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      buf_q <= '0;
      level <= '0;
      pend  <= 1'b0;
    end else if (cke_i) begin
      buf_q <= pend ? buf_s | item : buf_s;
      level <= pend ? lvl_s + w : lvl_s;
      pend  <= bus.read_o;
    end
  assign bus.wdata_o = buf_q[2*DATA_W-1 -: DATA_W];
endmodule

// File: tb/tb_iob_pack.sv
// tb_iob_pack: directed self-checking bench for iob_pack with a bitstream scoreboard.
module tb_iob_pack;
  localparam int D = 8;
  logic clk_i = 1'b0;
  logic cke_i, rst_i, wrap_i, flush_i;
  logic [3:0] width_i;
  iob_pack_if #(.DATA_W(D)) bus ();
  iob_pack #(.DATA_W(D)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .wrap_i(wrap_i),
    .width_i(width_i), .flush_i(flush_i), .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  int vecs = 0, errs = 0, n_cyc = 0;
  int up_q[$], rd_cyc[$], wr_cyc[$];
  logic [D-1:0] exp_q[$], got_q[$];
  logic up_en = 1'b0;

  task automatic chk(string nm, int act, int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Expected words from the item stream: concatenate bits MSB-first and cut
  // into words (continuous), or close a word as soon as the next item would not fit (wrap).
  function automatic void model(logic wr, int w, int its[$], logic fl);
    longint acc = 0;
    int nb = 0;
    foreach (its[i]) begin
      acc = (acc << w) | longint'(its[i]);
      nb += w;
      if (!wr && nb >= D) begin
        nb -= D;
        exp_q.push_back(D'(acc >> nb));
        acc = acc & ((longint'(1) << nb) - 1);
      end else if (wr && nb + w > D) begin
        exp_q.push_back(D'(acc << (D - nb)));
        acc = 0;
        nb = 0;
      end
    end
    if (fl && nb > 0) exp_q.push_back(D'(acc << (D - nb)));
  endfunction

  // One clock: check outputs at negedge, then play both FIFOs just after the posedge.
  task automatic cyc();
    logic rd;
    int it = 0;
    logic [D-1:0] j;
    @(negedge clk_i);
    n_cyc++;
    rd = bus.read_o;
    if (rst_i || !cke_i || flush_i) chk("read_blocked", int'(rd), 0);
    if (rst_i || !cke_i || !bus.wready_i) chk("write_blocked", int'(bus.write_o), 0);
    if (rd) begin
      rd_cyc.push_back(n_cyc);
      chk("read_nonempty", int'(up_q.size() > 0), 1);
      if (up_q.size() > 0) it = up_q.pop_front();
    end
    if (bus.write_o) begin
      wr_cyc.push_back(n_cyc);
      got_q.push_back(bus.wdata_o);
      chk("write_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("wdata", int'(bus.wdata_o), int'(exp_q.pop_front()));
    end
    @(posedge clk_i);
    #1;
    if (rd) begin
      j = D'($urandom);
      bus.rdata_i = (j << width_i) | D'(it);
    end
    bus.rready_i = up_en && up_q.size() > 0;
  endtask

  task automatic run(string nm, logic wr, int w, int its[$], logic fl, int stall, int stall_rd,
                     int gap, int lit[$]);
    int t;
    wrap_i = wr;
    width_i = 4'(w);
    flush_i = 1'b0;
    model(wr, w, its, fl);
    got_q.delete();
    rd_cyc.delete();
    wr_cyc.delete();
    bus.wready_i = stall == 0;
    up_q = its;
    up_en = 1'b1;
    bus.rready_i = 1'b1;
    if (stall > 0) begin
      repeat (stall) cyc();
      chk($sformatf("%s_stall_reads", nm), rd_cyc.size(), stall_rd);
      chk($sformatf("%s_stall_writes", nm), wr_cyc.size(), 0);
      bus.wready_i = 1'b1;
    end
    t = 0;
    while (up_q.size() > 0 && t < 200) begin
      cke_i = !(gap > 0 && t >= 2 && t < 2 + gap);
      cyc();
      t++;
    end
    cke_i = 1'b1;
    repeat (4) cyc();
    if (fl) begin
      flush_i = 1'b1;
      repeat (6) cyc();
      flush_i = 1'b0;
    end
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      cyc();
      t++;
    end
    repeat (3) cyc();
    chk($sformatf("%s_items_left", nm), up_q.size(), 0);
    chk($sformatf("%s_words_left", nm), exp_q.size(), 0);
    chk($sformatf("%s_count", nm), got_q.size(), lit.size());
    foreach (lit[i])
      chk($sformatf("%s_word%0d", nm, i), i < got_q.size() ? int'(got_q[i]) : -1, lit[i]);
  endtask

  initial begin
    int its[$], lit[$];
    int t;
    cke_i = 1'b1;
    rst_i = 1'b1;
    wrap_i = 1'b0;
    flush_i = 1'b0;
    width_i = 4'd4;
    bus.rready_i = 1'b0;
    bus.wready_i = 1'b1;
    bus.rdata_i = '0;
    repeat (2) cyc();
    chk("reset_wdata", int'(bus.wdata_o), 0);
    rst_i = 1'b0;
    // illegal widths never read
    width_i = 4'd0;
    up_q = {1};
    up_en = 1'b1;
    bus.rready_i = 1'b1;
    repeat (4) cyc();
    chk("w0_reads", rd_cyc.size(), 0);
    width_i = 4'd9;
    repeat (4) cyc();
    chk("w9_reads", rd_cyc.size(), 0);
    up_q.delete();
    bus.rready_i = 1'b0;
    repeat (2) cyc();
    its = {'hA, 'hB, 'hC, 'hD};
    lit = {'hAB, 'hCD};
    run("t1", 1'b0, 4, its, 1'b0, 0, 0, 0, lit);
    chk("t1_latency", (wr_cyc.size() > 0 && rd_cyc.size() > 1) ? wr_cyc[0] - rd_cyc[1] : -1, 2);
    its = {1, 2, 3, 4, 5, 6, 7, 0};
    lit = {'h29, 'hCB, 'hB8};
    run("t2", 1'b0, 3, its, 1'b0, 0, 0, 3, lit);
    its = {1, 2, 3, 4};
    lit = {'h28, 'h70};
    run("t3", 1'b1, 3, its, 1'b0, 0, 0, 0, lit);
    its = {5};
    lit = {'hA0};
    run("t4", 1'b0, 3, its, 1'b1, 0, 0, 0, lit);
    its = {1, 2, 3, 4, 5, 6, 7, 8};
    lit = {'h12, 'h34, 'h56, 'h78};
    run("t5", 1'b0, 4, its, 1'b0, 20, 3, 0, lit);
    its = {'h5A, 'hC3, 'h01};
    lit = {'h5A, 'hC3, 'h01};
    run("wfull", 1'b0, 8, its, 1'b0, 0, 0, 0, lit);
    its = {'h1F, 'h03};
    lit = {'hF8, 'h18};
    run("wrap5", 1'b1, 5, its, 1'b0, 0, 0, 0, lit);
    its = {1, 2, 3};
    lit = {'h28, 'h60};
    run("wrapfl", 1'b1, 3, its, 1'b1, 0, 0, 0, lit);
    // reset with one item landed (level 5) and a second read in flight
    wrap_i = 1'b0;
    width_i = 4'd5;
    got_q.delete();
    rd_cyc.delete();
    wr_cyc.delete();
    up_q = {'h1F, 'h15, 'h0A};
    bus.rready_i = 1'b1;
    t = 0;
    while (rd_cyc.size() < 2 && t < 20) begin
      cyc();
      t++;
    end
    chk("t6_pre_reads", rd_cyc.size(), 2);
    chk("t6_pre_wdata", int'(bus.wdata_o), 'hF8);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    up_q.delete();
    bus.rready_i = 1'b0;
    chk("t6_rst_wdata", int'(bus.wdata_o), 0);
    cyc();
    chk("t6_post_writes", wr_cyc.size(), 0);
    its = {'hA, 'hB};
    lit = {'hAB};
    run("t6", 1'b0, 4, its, 1'b0, 0, 0, 0, lit);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
